// File: rtl/carp_bol_birimi.sv
// Iterative RV32M multiply/divide unit: ADIM_BIT result bits per cycle, valid/ready on both
// sides, stall while busy, flush aborts the operation in flight.
module carp_bol_birimi #(
  parameter int VERI_BIT = 32,
  parameter int ADIM_BIT = 1,
  parameter int TAG_BIT  = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                bosalt_i,
  input  logic                istek_gecerli_i,
  output logic                istek_hazir_o,
  input  logic [2:0]          istek_islem_i,
  input  logic [VERI_BIT-1:0] istek_islec1_i,
  input  logic [VERI_BIT-1:0] istek_islec2_i,
  input  logic [TAG_BIT-1:0]  istek_etiket_i,
  output logic                sonuc_gecerli_o,
  input  logic                sonuc_hazir_i,
  output logic [VERI_BIT-1:0] sonuc_o,
  output logic [TAG_BIT-1:0]  sonuc_etiket_o,
  output logic                duraklat_o
);

  localparam int W       = VERI_BIT;
  localparam int ADIM_N  = VERI_BIT / ADIM_BIT;
  localparam int SAY_BIT = $clog2(ADIM_N) + 1;

  typedef enum logic [1:0] {BOS, HESAPLA, DUZELT, SONUC} durum_t;

  durum_t             r_durum;
  logic [SAY_BIT-1:0] r_sayac;
  logic [2:0]         r_islem;
  logic [W-1:0]       r_a, r_hi, r_lo, r_sonuc;
  logic               r_neg_q, r_neg_r, r_gecerli, r_duraklat;
  logic [TAG_BIT-1:0] r_etiket;

  logic               w_hazir, w_kabul, w_isaretli1, w_isaretli2, w_neg1, w_neg2;
  logic               w_bolen_sifir, w_tasma, w_hizli;
  logic [W-1:0]       w_mag1, w_mag2, w_hizli_sonuc, w_rem, w_quo, w_duzelt;
  logic [2*W:0]       w_m;
  logic [W:0]         w_kaydir;
  logic [2*W-1:0]     w_urun, w_urun_s;

  assign w_hazir = !rst_i && !bosalt_i &&
                   (r_durum == BOS || (r_durum == SONUC && sonuc_hazir_i));
  assign w_kabul = istek_gecerli_i && w_hazir;

  // MUL's low half is sign-agnostic, so it is treated as unsigned.
  assign w_isaretli1 = (istek_islem_i == 3'b001) || (istek_islem_i == 3'b010) ||
                       (istek_islem_i == 3'b100) || (istek_islem_i == 3'b110);
  assign w_isaretli2 = (istek_islem_i == 3'b001) || (istek_islem_i == 3'b100) ||
                       (istek_islem_i == 3'b110);
  assign w_neg1 = w_isaretli1 && istek_islec1_i[W-1];
  assign w_neg2 = w_isaretli2 && istek_islec2_i[W-1];
  assign w_mag1 = w_neg1 ? (~istek_islec1_i + 1'b1) : istek_islec1_i;
  assign w_mag2 = w_neg2 ? (~istek_islec2_i + 1'b1) : istek_islec2_i;

  assign w_bolen_sifir = istek_islem_i[2] && (istek_islec2_i == '0);
  assign w_tasma = istek_islem_i[2] && !istek_islem_i[0] &&
                   (istek_islec1_i == {1'b1, {(W-1){1'b0}}}) && (istek_islec2_i == '1);
  assign w_hizli = w_bolen_sifir || w_tasma;
  assign w_hizli_sonuc = w_bolen_sifir ? (istek_islem_i[1] ? istek_islec1_i : '1)
                                       : (istek_islem_i[1] ? '0 : istek_islec1_i);

  // One iteration step: shift-add product in {hi,lo} and restoring division in (rem,quo).
  always_comb begin
    w_m      = {1'b0, r_hi, r_lo};
    w_rem    = r_hi;
    w_quo    = r_lo;
    w_kaydir = '0;
    for (int k = 0; k < ADIM_BIT; k++) begin
      if (w_m[0]) w_m[2*W:W] = w_m[2*W:W] + {1'b0, r_a};
      w_m = w_m >> 1;
      w_kaydir = {w_rem, w_quo[W-1]};
      w_quo = {w_quo[W-2:0], 1'b0};
      if (w_kaydir >= {1'b0, r_a}) begin
        w_kaydir = w_kaydir - {1'b0, r_a};
        w_quo[0] = 1'b1;
      end
      w_rem = w_kaydir[W-1:0];
    end
  end

  always_comb begin
    w_urun   = {r_hi, r_lo};
    w_urun_s = r_neg_q ? (~w_urun + 1'b1) : w_urun;
    if (!r_islem[2])
      w_duzelt = (r_islem[1:0] == 2'b00) ? w_urun_s[W-1:0] : w_urun_s[2*W-1:W];
    else if (r_islem[1])
      w_duzelt = r_neg_r ? (~r_hi + 1'b1) : r_hi;
    else
      w_duzelt = r_neg_q ? (~r_lo + 1'b1) : r_lo;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_durum    <= BOS;
      r_sayac    <= '0;
      r_islem    <= '0;
      r_a        <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_sonuc    <= '0;
      r_etiket   <= '0;
      r_gecerli  <= 1'b0;
      r_duraklat <= 1'b0;
    end else if (bosalt_i) begin
      r_durum    <= BOS;
      r_sayac    <= '0;
      r_gecerli  <= 1'b0;
      r_duraklat <= 1'b0;
    end else begin
      case (r_durum)
        BOS, SONUC: begin
          if (w_kabul) begin
            r_islem    <= istek_islem_i;
            r_etiket   <= istek_etiket_i;
            r_neg_q    <= w_neg1 ^ w_neg2;
            r_neg_r    <= w_neg1;
            r_hi       <= '0;
            r_duraklat <= 1'b1;
            // Multiply keeps the multiplier in lo; divide keeps the dividend there.
            r_a  <= istek_islem_i[2] ? w_mag2 : w_mag1;
            r_lo <= istek_islem_i[2] ? w_mag1 : w_mag2;
            if (w_hizli) begin
              r_durum   <= SONUC;
              r_sonuc   <= w_hizli_sonuc;
              r_gecerli <= 1'b1;
            end else begin
              r_durum   <= HESAPLA;
              r_sayac   <= SAY_BIT'(ADIM_N - 1);
              r_gecerli <= 1'b0;
            end
          end else if (r_durum == SONUC && sonuc_hazir_i) begin
            r_durum    <= BOS;
            r_gecerli  <= 1'b0;
            r_duraklat <= 1'b0;
          end
        end
        HESAPLA: begin
          if (r_islem[2]) begin
            r_hi <= w_rem;
            r_lo <= w_quo;
          end else begin
            r_hi <= w_m[2*W-1:W];
            r_lo <= w_m[W-1:0];
          end
          if (r_sayac == '0) r_durum <= DUZELT;
          else               r_sayac <= r_sayac - SAY_BIT'(1);
        end
        DUZELT: begin
          r_sonuc   <= w_duzelt;
          r_gecerli <= 1'b1;
          r_durum   <= SONUC;
        end
        default: r_durum <= BOS;
      endcase
    end
  end

  assign istek_hazir_o   = w_hazir;
  assign sonuc_gecerli_o = r_gecerli;
  assign sonuc_o         = r_sonuc;
  assign sonuc_etiket_o  = r_etiket;
  assign duraklat_o      = r_duraklat;

endmodule

// File: tb/tb_carp_bol_birimi.sv
// Directed bench for carp_bol_birimi: three instances at ADIM_BIT = 1, 2, 4 (units 0, 1, 2).
module tb_carp_bol_birimi;

  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
  localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bosalt = 1'b0;
  logic        gec [3];
  logic        hazir_o [3];
  logic [2:0]  islem [3];
  logic [31:0] op1 [3];
  logic [31:0] op2 [3];
  logic [3:0]  etk [3];
  logic        sgec [3];
  logic        shazir [3];
  logic [31:0] sonuc [3];
  logic [3:0]  setk [3];
  logic        durak [3];

  int n_cmp = 0;
  int n_fail = 0;
  int lat_tab [3] = '{34, 18, 10};

  always #5 clk = ~clk;

  carp_bol_birimi #(.VERI_BIT(32), .ADIM_BIT(1), .TAG_BIT(4)) u_a1 (
    .clk_i(clk), .rst_i(rst), .bosalt_i(bosalt), .istek_gecerli_i(gec[0]), .istek_hazir_o(hazir_o[0]),
    .istek_islem_i(islem[0]), .istek_islec1_i(op1[0]), .istek_islec2_i(op2[0]), .istek_etiket_i(etk[0]),
    .sonuc_gecerli_o(sgec[0]), .sonuc_hazir_i(shazir[0]), .sonuc_o(sonuc[0]), .sonuc_etiket_o(setk[0]),
    .duraklat_o(durak[0]));
  carp_bol_birimi #(.VERI_BIT(32), .ADIM_BIT(2), .TAG_BIT(4)) u_a2 (
    .clk_i(clk), .rst_i(rst), .bosalt_i(bosalt), .istek_gecerli_i(gec[1]), .istek_hazir_o(hazir_o[1]),
    .istek_islem_i(islem[1]), .istek_islec1_i(op1[1]), .istek_islec2_i(op2[1]), .istek_etiket_i(etk[1]),
    .sonuc_gecerli_o(sgec[1]), .sonuc_hazir_i(shazir[1]), .sonuc_o(sonuc[1]), .sonuc_etiket_o(setk[1]),
    .duraklat_o(durak[1]));
  carp_bol_birimi #(.VERI_BIT(32), .ADIM_BIT(4), .TAG_BIT(4)) u_a4 (
    .clk_i(clk), .rst_i(rst), .bosalt_i(bosalt), .istek_gecerli_i(gec[2]), .istek_hazir_o(hazir_o[2]),
    .istek_islem_i(islem[2]), .istek_islec1_i(op1[2]), .istek_islec2_i(op2[2]), .istek_etiket_i(etk[2]),
    .sonuc_gecerli_o(sgec[2]), .sonuc_hazir_i(shazir[2]), .sonuc_o(sonuc[2]), .sonuc_etiket_o(setk[2]),
    .duraklat_o(durak[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Presents one request and leaves the bench at the negedge of cycle 1.
  task automatic gonder(input int u, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] tag, input string ad);
    @(negedge clk);
    gec[u] = 1'b1; islem[u] = op; op1[u] = a; op2[u] = b; etk[u] = tag;
    #1;
    chk({ad, "_hazir"}, 32'(hazir_o[u]), 32'd1);
    tick();
    gec[u] = 1'b0;
  endtask

  // Counts cycles (accept edge = 0) until the result is valid, watching the stall line.
  task automatic bekle(input int u, output int c, output logic stall_ok);
    c = 1;
    stall_ok = 1'b1;
    while (!sgec[u] && c < 200) begin
      if (!durak[u]) stall_ok = 1'b0;
      tick();
      c++;
    end
    if (!durak[u]) stall_ok = 1'b0;
  endtask

  task automatic tuket(input int u, input string ad);
    shazir[u] = 1'b1;
    tick();
    shazir[u] = 1'b0;
    chk({ad, "_gecerli_dusus"}, 32'(sgec[u]), 32'd0);
    chk({ad, "_duraklat_dusus"}, 32'(durak[u]), 32'd0);
  endtask

  task automatic calistir(input int u, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] tag, input logic [31:0] exp, input int lat, input string ad);
    int c;
    logic ok;
    gonder(u, op, a, b, tag, ad);
    bekle(u, c, ok);
    $display("islem %s birim %0d: sonuc %h etiket %h gecikme %0d", ad, u, sonuc[u], setk[u], c);
    chk({ad, "_gecikme"}, 32'(c), 32'(lat));
    chk({ad, "_sonuc"}, sonuc[u], exp);
    chk({ad, "_etiket"}, 32'(setk[u]), 32'(tag));
    chk({ad, "_duraklat"}, 32'(ok), 32'd1);
    tuket(u, ad);
  endtask

  initial begin
    int c;
    logic ok;
    logic goruldu;
    for (int i = 0; i < 3; i++) begin
      gec[i] = 1'b0; islem[i] = '0; op1[i] = '0; op2[i] = '0; etk[i] = '0; shazir[i] = 1'b0;
    end

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_gecerli", 32'(sgec[0]), 32'd0);
    chk("rst_duraklat", 32'(durak[0]), 32'd0);
    chk("rst_sonuc", sonuc[0], 32'd0);
    chk("rst_etiket", 32'(setk[0]), 32'd0);
    chk("rst_hazir", 32'(hazir_o[0]), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_sonra_hazir", 32'(hazir_o[0]), 32'd1);

    calistir(0, MUL, 32'd7, 32'hFFFFFFFD, 4'd5, 32'hFFFFFFEB, 34, "mul");
    for (int u = 0; u < 3; u++) begin
      calistir(u, MULH,   32'h80000000, 32'h80000000, 4'd1, 32'h40000000, lat_tab[u], "mulh");
      calistir(u, MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 4'd2, 32'hFFFFFFFE, lat_tab[u], "mulhu");
      calistir(u, MULHSU, 32'hFFFFFFFF, 32'd2,        4'd3, 32'hFFFFFFFF, lat_tab[u], "mulhsu");
    end

    calistir(0, DIVU, 32'h1234,     32'd0,        4'd6, 32'hFFFFFFFF, 1, "divu_sifir");
    calistir(0, REM,  32'h1234,     32'd0,        4'd7, 32'h00001234, 1, "rem_sifir");
    calistir(0, DIV,  32'h80000000, 32'hFFFFFFFF, 4'd8, 32'h80000000, 1, "div_tasma");
    calistir(0, REM,  32'h80000000, 32'hFFFFFFFF, 4'd9, 32'h00000000, 1, "rem_tasma");

    calistir(0, DIV,  32'hFFFFFFF9, 32'd2, 4'd1, 32'hFFFFFFFD, 34, "div");
    calistir(0, REM,  32'hFFFFFFF9, 32'd2, 4'd2, 32'hFFFFFFFF, 34, "rem");
    calistir(0, DIVU, 32'd100,      32'd7, 4'd3, 32'd14,       34, "divu");
    calistir(0, REMU, 32'd100,      32'd7, 4'd4, 32'd2,        34, "remu");

    // Back-pressure, then result handshake and new accept on the same edge
    gonder(1, DIVU, 32'd100, 32'd7, 4'd3, "bp1");
    bekle(1, c, ok);
    chk("bp1_sonuc", sonuc[1], 32'd14);
    for (int i = 0; i < 5; i++) begin
      tick();
      $display("geri basinc dongu %0d: gecerli %0d sonuc %h etiket %h", i, sgec[1], sonuc[1], setk[1]);
      chk("bp_gecerli_sabit", 32'(sgec[1]), 32'd1);
      chk("bp_sonuc_sabit", sonuc[1], 32'd14);
      chk("bp_etiket_sabit", 32'(setk[1]), 32'd3);
    end
    shazir[1] = 1'b1;
    gec[1] = 1'b1; islem[1] = REMU; op1[1] = 32'd100; op2[1] = 32'd7; etk[1] = 4'd9;
    #1;
    chk("b2b_hazir", 32'(hazir_o[1]), 32'd1);
    tick();
    gec[1] = 1'b0;
    shazir[1] = 1'b0;
    chk("b2b_gecerli_dustu", 32'(sgec[1]), 32'd0);
    bekle(1, c, ok);
    $display("ardisik islem: sonuc %h etiket %h gecikme %0d", sonuc[1], setk[1], c);
    chk("b2b_gecikme", 32'(c), 32'd18);
    chk("b2b_sonuc", sonuc[1], 32'd2);
    chk("b2b_etiket", 32'(setk[1]), 32'd9);
    tuket(1, "b2b");

    // Flush in HESAPLA cycle 10
    gonder(0, MUL, 32'd5, 32'd6, 4'd1, "bosalt");
    repeat (9) tick();
    chk("bosalt_once_duraklat", 32'(durak[0]), 32'd1);
    bosalt = 1'b1;
    tick();
    bosalt = 1'b0;
    #1;
    $display("bosaltma: duraklat %0d gecerli %0d hazir %0d", durak[0], sgec[0], hazir_o[0]);
    chk("bosalt_duraklat", 32'(durak[0]), 32'd0);
    chk("bosalt_gecerli", 32'(sgec[0]), 32'd0);
    chk("bosalt_hazir", 32'(hazir_o[0]), 32'd1);
    goruldu = 1'b0;
    repeat (40) begin
      tick();
      if (sgec[0]) goruldu = 1'b1;
    end
    chk("bosalt_sonuc_yok", 32'(goruldu), 32'd0);

    // Request together with flush is not accepted
    gec[0] = 1'b1; islem[0] = MUL; op1[0] = 32'd3; op2[0] = 32'd3; etk[0] = 4'd2;
    bosalt = 1'b1;
    #1;
    chk("bosalt_istek_hazir", 32'(hazir_o[0]), 32'd0);
    tick();
    gec[0] = 1'b0;
    bosalt = 1'b0;
    $display("bosalt+istek: duraklat %0d gecerli %0d", durak[0], sgec[0]);
    chk("bosalt_istek_duraklat", 32'(durak[0]), 32'd0);
    chk("bosalt_istek_gecerli", 32'(sgec[0]), 32'd0);

    // Reset mid-operation
    gonder(0, DIV, 32'd1000, 32'd3, 4'hA, "rst_orta");
    repeat (5) tick();
    rst = 1'b1;
    tick();
    #1;
    $display("orta reset: gecerli %0d duraklat %0d sonuc %h etiket %h hazir %0d",
             sgec[0], durak[0], sonuc[0], setk[0], hazir_o[0]);
    chk("rst_orta_gecerli", 32'(sgec[0]), 32'd0);
    chk("rst_orta_duraklat", 32'(durak[0]), 32'd0);
    chk("rst_orta_sonuc", sonuc[0], 32'd0);
    chk("rst_orta_etiket", 32'(setk[0]), 32'd0);
    chk("rst_orta_hazir", 32'(hazir_o[0]), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_orta_sonra_hazir", 32'(hazir_o[0]), 32'd1);
    calistir(0, MUL, 32'd12, 32'd11, 4'hB, 32'd132, 34, "rst_sonra_mul");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/carp_bol_birimi.md
# carp_bol_birimi

Iterative, parametrised RV32M multiply/divide unit for the execute stage, the first multi-cycle functional unit beside the single-cycle ALU. Accepts one operation through a valid/ready request handshake, iterates `ADIM_BIT` result bits per cycle, and returns the result plus the request tag through a valid/ready response handshake. While the unit is busy it raises a stall to the pipeline, and it honours the pipeline flush.

## Interface
Parameters:
- `VERI_BIT`, 32: operand and result width.
- `ADIM_BIT`, 1: bits processed per iteration cycle. Allowed values are 1, 2 and 4, and the value must divide `VERI_BIT`.
- `TAG_BIT`, 4: width of the tag passed through unchanged.

Ports (one clock; reset is synchronous and active-high):
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `bosalt_i`  in  1  flush: abort the operation in flight.
- `istek_gecerli_i`  in  1  request valid.
- `istek_hazir_o`  out  1  request ready.
- `istek_islem_i`  in  3  operation, RV32M funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `istek_islec1_i`  in  `VERI_BIT`  rs1 operand (multiplicand / dividend).
- `istek_islec2_i`  in  `VERI_BIT`  rs2 operand (multiplier / divisor).
- `istek_etiket_i`  in  `TAG_BIT`  request tag.
- `sonuc_gecerli_o`  out  1  result valid.
- `sonuc_hazir_i`  in  1  consumer ready.
- `sonuc_o`  out  `VERI_BIT`  result.
- `sonuc_etiket_o`  out  `TAG_BIT`  tag of the result.
- `duraklat_o`  out  1  stall request; high whenever the unit is not in BOS.

## Operation
**Handshake**
- A request is accepted on a rising edge where `istek_gecerli_i && istek_hazir_o`.
- `istek_hazir_o = !rst_i && !bosalt_i && (state==BOS || (state==SONUC && sonuc_hazir_i))`.

**State machine**
- BOS: idle. On accept, go to HESAPLA, or go straight to SONUC when a fast-path case applies.
- HESAPLA: stay for N = `VERI_BIT`/`ADIM_BIT` cycles. An iteration counter of width clog2(N)+1 counts down from N-1.
- DUZELT: one cycle for sign correction and upper/lower half selection.
- SONUC: result held. On `sonuc_hazir_i`, go to BOS, or to the next request's state if a new request is accepted in the same cycle.

**Arithmetic**
- At accept, latch the operands as magnitudes and record the result sign.
- Signedness per operation:
  - MULH: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU, DIVU, REMU: both unsigned.
  - DIV, REM: both signed.
- Multiply: shift-add over a 2·`VERI_BIT`-bit product, consuming `ADIM_BIT` multiplier bits per cycle. MUL returns the low half; the MULH variants return the high half of the signed-corrected product.
- Divide: restoring division, producing `ADIM_BIT` quotient bits per cycle.
  - Quotient sign is sign(rs1) XOR sign(rs2).
  - Remainder takes the sign of rs1.

**Fast path** (go directly to SONUC, skipping HESAPLA and DUZELT)
- Divisor zero: DIV/DIVU return all ones; REM/REMU return rs1.
- Signed overflow, rs1 = most-negative value and rs2 = -1:
  - DIV returns rs1.
  - REM returns 0.

**Flush**
- `bosalt_i` in any state: the next state is BOS and the result is discarded. `sonuc_gecerli_o` is low from the next cycle.
- A request presented together with `bosalt_i` is not accepted.
- `bosalt_i` has priority over an accept or a result handshake in the same cycle.

**Reset**
- `rst_i` high: the next state is BOS and the counter is cleared, regardless of the other inputs, including mid-operation.

## Timing
Reset values:
- `sonuc_gecerli_o` = 0, `duraklat_o` = 0.
- `sonuc_o` = 0, `sonuc_etiket_o` = 0.
- `istek_hazir_o` = 0 while `rst_i` is high, then 1.

Latency, with the accept edge as cycle 0:
- Normal operation: HESAPLA in cycles 1..N, DUZELT in cycle N+1, `sonuc_gecerli_o` high from cycle N+2. This gives 34 cycles for 32/1, 18 for 32/2 and 10 for 32/4.
- Fast path: `sonuc_gecerli_o` high in cycle 1.

Output and stall behaviour:
- `sonuc_o` and `sonuc_etiket_o` are registered outputs. They stay stable while `sonuc_gecerli_o && !sonuc_hazir_i`.
- `duraklat_o` is registered and is high in HESAPLA, DUZELT and SONUC.

Throughput:
- Back-to-back requests: a result handshake and a new accept may occur on the same edge. Peak throughput is one op per N+2 cycles, or one per cycle for consecutive fast-path ops.

## Test plan
- MUL 7 × 0xFFFFFFFD (-3), ADIM_BIT=1, tag 5 → `sonuc_o`=0xFFFFFFEB and `sonuc_etiket_o`=5. `sonuc_gecerli_o` rises exactly 34 cycles after accept; `duraklat_o` is high in cycles 1..34.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF. Repeat each at ADIM_BIT=2 and 4, with results valid at cycle 18 and cycle 10 respectively.
- DIV 0xFFFFFFF9 (-7) / 2 → 0xFFFFFFFD. REM on the same operands → 0xFFFFFFFF. DIVU 100 / 7 → 14. REMU 100 / 7 → 2.
- Fast path, each result valid at cycle 1:
  - DIVU 0x1234 / 0 → 0xFFFFFFFF.
  - REM 0x1234 / 0 → 0x1234.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM 0x80000000 / 0xFFFFFFFF → 0.
- Back-pressure and back-to-back: hold `sonuc_hazir_i` low for 5 cycles; `sonuc_o` and the tag must stay stable. Then raise `sonuc_hazir_i` together with a new request: both handshakes occur on the same edge, and the second result arrives N+2 cycles later.
- Abort paths:
  - Pulse `bosalt_i` in HESAPLA cycle 10 → state BOS next cycle, no `sonuc_gecerli_o`, `istek_hazir_o` high again.
  - Assert `rst_i` mid-operation → all outputs at their reset values on the next cycle.
  - A request presented together with `bosalt_i` is not accepted.
